// File: rtl/switch_in_port_if.sv
// CPU-side read bus of the switch input port: read strobe, word select, read data and interrupt.
interface switch_in_port_if;
    logic        io_rd;
    logic [1:0]  io_addr;
    logic [31:0] io_rdata;
    logic        irq;

    modport master (
        output io_rd,
        output io_addr,
        input  io_rdata,
        input  irq
    );

    modport slave (
        input  io_rd,
        input  io_addr,
        output io_rdata,
        output irq
    );
endinterface

// File: rtl/switch_in_port.sv
// Debounced, memory-mapped switch/key input port with sticky change/rise flags cleared by CPU reads.
module switch_in_port #(
    parameter int unsigned WIDTH    = 10,
    parameter int unsigned DEBOUNCE = 250000
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic [WIDTH-1:0]   pin_in,
    switch_in_port_if.slave    io
);

    localparam int unsigned      CNT_W    = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_RISE   = 2'd2;
    localparam logic [1:0] ADDR_RAW    = 2'd3;

    logic [WIDTH-1:0] sync1_q,  sync1_d;
    logic [WIDTH-1:0] sync2_q,  sync2_d;
    logic [WIDTH-1:0] stable_q, stable_d;
    logic [WIDTH-1:0] rise_q,   rise_d;
    logic             changed_q, changed_d;
    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];

    logic [WIDTH-1:0] rise_set;
    logic             any_change;
    logic             clr_changed;
    logic             clr_rise;

    // Two-flop synchronizer; only sync2 is used downstream.
    always_comb begin
        sync1_d = pin_in;
        sync2_d = sync1_q;
    end

    // Per-bit debounce: a bit is accepted after DEBOUNCE consecutive mismatching cycles.
    always_comb begin
        stable_d = stable_q;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (sync2_q[i] == stable_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                stable_d[i] = sync2_q[i];
                cnt_d[i]    = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    // Sticky flags; a transition on the same edge as a clearing read keeps the flag set.
    always_comb begin
        rise_set    = stable_d & ~stable_q;
        any_change  = |(stable_d ^ stable_q);
        clr_changed = io.io_rd && ((io.io_addr == ADDR_DATA) || (io.io_addr == ADDR_STATUS));
        clr_rise    = io.io_rd && (io.io_addr == ADDR_RISE);
        rise_d      = (clr_rise ? '0 : rise_q) | rise_set;
        changed_d   = (changed_q && !clr_changed) || any_change;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            stable_q  <= '0;
            rise_q    <= '0;
            changed_q <= 1'b0;
            for (int unsigned i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            stable_q  <= stable_d;
            rise_q    <= rise_d;
            changed_q <= changed_d;
            for (int unsigned i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Read mux is combinational from registers and independent of io_rd.
    always_comb begin
        io.io_rdata = '0;
        case (io.io_addr)
            ADDR_DATA:   io.io_rdata = 32'(stable_q);
            ADDR_STATUS: io.io_rdata = 32'(changed_q);
            ADDR_RISE:   io.io_rdata = 32'(rise_q);
            ADDR_RAW:    io.io_rdata = 32'(sync2_q);
            default:     io.io_rdata = '0;
        endcase
    end

    assign io.irq = |rise_q;

endmodule

// File: tb/tb_switch_in_port.sv
// Directed bench for switch_in_port with DEBOUNCE=4: reset, debounce latency, glitch rejection, read clears.
module tb_switch_in_port;

    localparam int unsigned WIDTH    = 10;
    localparam int unsigned DEBOUNCE = 4;

    logic             clk;
    logic             resetn;
    logic [WIDTH-1:0] pin_in;
    int               n_checks;
    int               n_fail;

    switch_in_port_if bus ();

    switch_in_port #(
        .WIDTH    (WIDTH),
        .DEBOUNCE (DEBOUNCE)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .pin_in (pin_in),
        .io     (bus.slave)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic peek(input logic [1:0] a, output logic [31:0] v);
        bus.io_rd   = 1'b0;
        bus.io_addr = a;
        #1;
        v = bus.io_rdata;
    endtask

    // Side-effect-free check of DATA, STATUS, RISE and irq.
    task automatic chk_regs(input string tag, input logic [31:0] data, input logic [31:0] status,
                            input logic [31:0] rise, input logic irq_exp);
        logic [31:0] v;
        peek(2'd0, v); chk({tag, "_data"},   v, data);
        peek(2'd1, v); chk({tag, "_status"}, v, status);
        peek(2'd2, v); chk({tag, "_rise"},   v, rise);
        chk({tag, "_irq"}, 32'(bus.irq), 32'(irq_exp));
    endtask

    // One-cycle CPU read; checks the data presented during the access.
    task automatic do_read(input logic [1:0] a, input logic [31:0] exp, input string tag);
        bus.io_addr = a;
        bus.io_rd   = 1'b1;
        #1;
        chk(tag, bus.io_rdata, exp);
        tick(1);
        bus.io_rd = 1'b0;
    endtask

    initial begin
        logic [31:0] v;
        n_checks    = 0;
        n_fail      = 0;
        resetn      = 1'b0;
        pin_in      = 10'h3FF;
        bus.io_rd   = 1'b0;
        bus.io_addr = 2'd0;

        // Reset with all pins high, then release between edges.
        tick(3);
        chk_regs("rst", 32'h0, 32'h0, 32'h0, 1'b0);
        peek(2'd3, v); chk("rst_raw", v, 32'h0);
        resetn = 1'b1;
        tick(1);
        peek(2'd3, v); chk("raw_k", v, 32'h0);
        tick(1);
        peek(2'd3, v); chk("raw_k1", v, 32'h3FF);
        tick(3);
        chk_regs("pre_accept", 32'h0, 32'h0, 32'h0, 1'b0);
        tick(1);
        chk_regs("accept", 32'h3FF, 32'h1, 32'h3FF, 1'b1);

        // Falling edge on bit 9 sets changed but not rise.
        do_read(2'd0, 32'h3FF, "rd_data_clr");
        chk_regs("clr_chg", 32'h3FF, 32'h0, 32'h3FF, 1'b1);
        pin_in = 10'h1FF;
        tick(5);
        chk_regs("fall_pre", 32'h3FF, 32'h0, 32'h3FF, 1'b1);
        tick(1);
        chk_regs("fall", 32'h1FF, 32'h1, 32'h3FF, 1'b1);

        // Clear rise and changed.
        do_read(2'd2, 32'h3FF, "rd_rise_all");
        chk_regs("rise_clr", 32'h1FF, 32'h1, 32'h0, 1'b0);
        do_read(2'd1, 32'h1, "rd_status");
        chk_regs("stat_clr", 32'h1FF, 32'h0, 32'h0, 1'b0);

        // All bits fall together: changed set once, no rise.
        pin_in = 10'h000;
        tick(8);
        chk_regs("all_fall", 32'h0, 32'h1, 32'h0, 1'b0);
        do_read(2'd0, 32'h0, "rd_data0");

        // 3-cycle glitch on bit 0 never reaches stable.
        pin_in = 10'h001;
        tick(3);
        pin_in = 10'h000;
        tick(8);
        chk_regs("glitch", 32'h0, 32'h0, 32'h0, 1'b0);

        // 6-cycle pulse on bit 0, then held high.
        pin_in = 10'h001;
        tick(6);
        chk_regs("pulse", 32'h1, 32'h1, 32'h1, 1'b1);

        // Read-clear of RISE and STATUS.
        do_read(2'd2, 32'h1, "rd_rise1");
        chk_regs("rise1_clr", 32'h1, 32'h1, 32'h0, 1'b0);
        do_read(2'd0, 32'h1, "rd_data1");
        chk_regs("chg1_clr", 32'h1, 32'h0, 32'h0, 1'b0);

        // Re-arm rise bit 0: fall, rise, clear changed only.
        pin_in = 10'h000;
        tick(8);
        pin_in = 10'h001;
        tick(6);
        do_read(2'd1, 32'h1, "rd_status2");
        chk_regs("rearm", 32'h1, 32'h0, 32'h1, 1'b1);

        // Bit 3 rise lands on the same edge as a RISE read.
        pin_in = 10'h009;
        tick(5);
        chk_regs("coll_pre", 32'h1, 32'h0, 32'h1, 1'b1);
        do_read(2'd2, 32'h1, "coll_rdata");
        chk_regs("coll", 32'h9, 32'h1, 32'h8, 1'b1);

        // Async reset two cycles into a 0->1 count, released with pins held.
        pin_in = 10'h0F9;
        tick(4);
        #2;
        resetn = 1'b0;
        #1;
        chk_regs("arst", 32'h0, 32'h0, 32'h0, 1'b0);
        peek(2'd3, v); chk("arst_raw", v, 32'h0);
        tick(1);
        resetn = 1'b1;
        tick(5);
        chk_regs("arst_pre", 32'h0, 32'h0, 32'h0, 1'b0);
        peek(2'd3, v); chk("arst_raw2", v, 32'h0F9);
        tick(1);
        chk_regs("arst_acc", 32'h0F9, 32'h1, 32'h0F9, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
